// File: rtl/fib_stack_engine.sv
// fib_stack_engine
//   Computes F(n) with explicit-stack recursion. Each leaf (x <= 1) adds x
//   to the accumulator. A stack overflow aborts the run and raises err.
//
//   Ports
//     i_clk     clock; all state changes on its rising edge
//     i_rst     synchronous active-high reset
//     i_start   request to compute F(i_n_in); honoured only in IDLE
//     i_n_in    operand n, captured on the accepted start edge
//     o_busy    high in every state except IDLE
//     o_done    one-cycle completion pulse (normal or error end)
//     o_result  F(n), or the partial sum on error; held until the next done
//     o_ovf     sticky: accumulator overflowed during this computation
//     o_err     sticky: stack overflow aborted this computation
//
//   Build option
//     FIB_SATURATE_EN  when defined, the accumulator clamps to all-ones on
//                      overflow; otherwise it wraps modulo 2^WIDTH.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   S_IDLE   | waiting for start
//   S_POP    | pop top of stack; leaf -> accumulate, else expand
//   S_PUSH_A | push x-1
//   S_PUSH_B | push x-2
//   S_DONE   | done pulse, result valid
//   S_ERR    | done pulse with err, partial result
module fib_stack_engine #(
  parameter int WIDTH = 16,
  parameter int NW    = 8,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [NW-1:0]    i_n_in,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_ovf,
  output logic             o_err
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_PUSH_A, S_PUSH_B, S_DONE, S_ERR
  } state_t;

  state_t           r_state;
  logic [SPW-1:0]   r_sp;
  logic [WIDTH-1:0] r_acc;
  logic [NW-1:0]    r_x;
  logic [NW-1:0]    r_stack [DEPTH];

  logic [SPW-1:0]   w_sp_m1;
  logic [NW-1:0]    w_top;
  logic             w_full;
  logic             w_leaf;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_we;
  logic [AW-1:0]    w_wa;
  logic [NW-1:0]    w_wd;

  assign w_sp_m1 = r_sp - SPW'(1);
  // Only meaningful when r_sp > 0; POP checks that before using it.
  assign w_top   = r_stack[w_sp_m1[AW-1:0]];
  assign w_full  = (r_sp == SPW'(DEPTH));
  assign w_leaf  = (w_top <= NW'(1));
  // A leaf contributes 0 or 1, so only bit 0 of the popped value matters.
  assign w_sum   = {1'b0, r_acc} + {{WIDTH{1'b0}}, w_top[0]};

`ifdef FIB_SATURATE_EN
  // Once clamped, adding 1 carries again, so the value stays at all-ones.
  assign w_acc_next = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
`else
  assign w_acc_next = w_sum[WIDTH-1:0];
`endif

  always_comb begin
    w_we = 1'b0;
    w_wa = r_sp[AW-1:0];
    w_wd = r_x - NW'(1);
    case (r_state)
      S_IDLE: begin
        w_we = i_start;
        w_wa = '0;
        w_wd = i_n_in;
      end
      S_PUSH_A: w_we = ~w_full;
      S_PUSH_B: begin
        w_we = ~w_full;
        w_wd = r_x - NW'(2);
      end
      default: w_we = 1'b0;
    endcase
  end

  // Stack storage is not reset; entries at or above sp are don't-care.
  always_ff @(posedge i_clk) begin
    if (w_we) r_stack[w_wa] <= w_wd;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_sp     <= '0;
      r_acc    <= '0;
      r_x      <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_result <= '0;
      o_ovf    <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_sp    <= SPW'(1);
            r_acc   <= '0;
            o_ovf   <= 1'b0;
            o_err   <= 1'b0;
            o_busy  <= 1'b1;
            r_state <= S_POP;
          end
        end
        S_POP: begin
          if (r_sp == '0) begin
            o_done   <= 1'b1;
            o_result <= r_acc;
            r_state  <= S_DONE;
          end else begin
            r_sp <= w_sp_m1;
            if (w_leaf) begin
              r_acc <= w_acc_next;
              if (w_sum[WIDTH]) o_ovf <= 1'b1;
            end else begin
              r_x     <= w_top;
              r_state <= S_PUSH_A;
            end
          end
        end
        S_PUSH_A, S_PUSH_B: begin
          if (w_full) begin
            o_done   <= 1'b1;
            o_err    <= 1'b1;
            o_result <= r_acc;
            r_state  <= S_ERR;
          end else begin
            r_sp    <= r_sp + SPW'(1);
            r_state <= (r_state == S_PUSH_A) ? S_PUSH_B : S_POP;
          end
        end
        S_DONE, S_ERR: begin
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
